// File: rtl/dcache_ctrl_pkg.sv
// Shared types and encodings for the data cache control FSM.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    RELOOK    = 2'd3
  } state_t;

  // pmem address mux: request {tag, index} or victim {tag, index}
  localparam logic PMEM_ADDR_REQ    = 1'b0;
  localparam logic PMEM_ADDR_VICTIM = 1'b1;

  // data array write source: CPU byte-enable merge or pmem line fill
  localparam logic DATA_SRC_CPU = 1'b0;
  localparam logic DATA_SRC_MEM = 1'b1;

endpackage

// File: rtl/dcache_sat_counter.sv
// Saturating up-counter used for the hit/miss performance counters.
module dcache_sat_counter
  import dcache_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_reg;

  // Count up on inc, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dcache_controller.sv
// Data cache control FSM: hit responses, dirty-victim writeback,
// line allocate and a one-cycle re-lookup of the filled line.
module dcache_controller
  import dcache_ctrl_pkg::*;
#(
  parameter int LOG2_WAYS = 3,
  parameter int NUM_WAYS  = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic                 hit,
  input  logic [LOG2_WAYS-1:0] hit_way,
  input  logic [LOG2_WAYS-1:0] lru_way,
  input  logic                 victim_valid,
  input  logic                 victim_dirty,
  input  logic                 pmem_resp,
  output logic                 load,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 pmem_addr_sel,
  output logic [LOG2_WAYS-1:0] way_sel,
  output logic                 data_we,
  output logic                 data_src,
  output logic                 tag_we,
  output logic                 valid_set,
  output logic                 dirty_set,
  output logic                 dirty_clr,
  output logic                 lru_we,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  // Victim register width; kept at least one bit for a direct-mapped build.
  localparam int WAY_BITS = (NUM_WAYS > 1) ? LOG2_WAYS : 1;

  state_t              state_reg, state_next;
  logic [WAY_BITS-1:0] victim_way_reg, victim_way_next;
  logic                req_any;
  logic                req_is_write;
  logic                hit_inc;
  logic                miss_inc;

  assign req_any      = req_read | req_write;
  assign req_is_write = req_write;  // read+write together is a write

  // State and victim-way registers; reset drops any pmem transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= COMPARE;
      victim_way_reg <= '0;
    end else begin
      state_reg      <= state_next;
      victim_way_reg <= victim_way_next;
    end
  end

  // Next-state and control outputs; everything idles low unless a state drives it.
  always_comb begin
    state_next      = state_reg;
    victim_way_next = victim_way_reg;
    load            = 1'b0;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_addr_sel   = PMEM_ADDR_REQ;
    way_sel         = '0;
    data_we         = 1'b0;
    data_src        = DATA_SRC_CPU;
    tag_we          = 1'b0;
    valid_set       = 1'b0;
    dirty_set       = 1'b0;
    dirty_clr       = 1'b0;
    lru_we          = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;

    unique case (state_reg)
      COMPARE: begin
        if (!req_any) begin
          load = 1'b1;
        end else if (hit) begin
          mem_resp  = 1'b1;
          load      = 1'b1;
          lru_we    = 1'b1;
          way_sel   = hit_way;
          data_we   = req_is_write;
          dirty_set = req_is_write;
          hit_inc   = 1'b1;
        end else begin
          // Capture the victim now so later LRU changes cannot retarget the fill.
          victim_way_next = lru_way;
          miss_inc        = 1'b1;
          state_next      = (victim_valid & victim_dirty) ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = PMEM_ADDR_VICTIM;
        way_sel       = victim_way_reg;
        if (pmem_resp) begin
          state_next = ALLOCATE;
        end
      end

      ALLOCATE: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = PMEM_ADDR_REQ;
        if (pmem_resp) begin
          way_sel    = victim_way_reg;
          data_we    = 1'b1;
          data_src   = DATA_SRC_MEM;
          tag_we     = 1'b1;
          valid_set  = 1'b1;
          dirty_clr  = 1'b1;
          state_next = RELOOK;
        end
      end

      RELOOK: begin
        // Filled line is now visible; finish like a hit on the victim way.
        mem_resp   = 1'b1;
        load       = 1'b1;
        lru_we     = 1'b1;
        way_sel    = victim_way_reg;
        data_we    = req_is_write;
        dirty_set  = req_is_write;
        state_next = COMPARE;
      end

      default: state_next = COMPARE;
    endcase
  end

  dcache_sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  dcache_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule
